// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold, MSB-first bit trials, single-shot or round-robin scan.
// Optional ADC_AVG_EN: each result is the truncated mean of 2^AVG_LOG2 back-to-back conversions.
`timescale 1ns/1ps
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int NUM_CH        = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int AVG_LOG2      = 2,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             scan,
  input  logic [CH_W-1:0]  ch_req,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] bitctrl,
  output logic [CH_W-1:0]  ch_sel,
  output logic             sample,
  output logic             busy,
  output logic [WIDTH-1:0] D,
  output logic [CH_W-1:0]  d_ch,
  output logic             valid
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] code_kept;
  logic [WIDTH-1:0] result;
  logic [CH_W-1:0]  ch_next;
  logic             start_ok;
  logic             sample_end;
  logic             bit_end;
  logic             conv_end;
  logic             last_sub;

  assign start_ok   = start && (scan || (int'(ch_req) < NUM_CH));
  assign sample_end = (state == SAMPLE)  && (cnt == CNT_W'(SAMPLE_CYCLES - 1));
  assign bit_end    = (state == CONVERT) && (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign conv_end   = bit_end && (bit_idx == '0);
  assign trial      = code | (WIDTH'(1) << bit_idx);
  assign code_kept  = cmp_in ? trial : code;
  assign ch_next    = (int'(ch_sel) == NUM_CH - 1) ? '0 : ch_sel + CH_W'(1);

`ifdef ADC_AVG_EN
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int SUB_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [SUB_W-1:0] sub;

  assign acc_sum  = acc + ACC_W'(code_kept);
  assign last_sub = (sub == SUB_W'((1 << AVG_LOG2) - 1));
  assign result   = WIDTH'(acc_sum >> AVG_LOG2);
`else
  assign last_sub = 1'b1;
  assign result   = code_kept;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // valid is only set at the end of the final sub-conversion, so in DONE it
  // also tells whether another averaging pass on the same channel is due.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    sample    = 1'b0;
    bitctrl   = '0;
    case (state)
      IDLE:    if (start_ok) state_nxt = SAMPLE;
      SAMPLE: begin
        sample = 1'b1;
        if (sample_end) state_nxt = CONVERT;
      end
      CONVERT: begin
        bitctrl = trial;
        if (conv_end) state_nxt = DONE;
      end
      DONE: begin
        bitctrl   = code;
        state_nxt = (!valid || scan) ? SAMPLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // D/d_ch/valid are registered on the last bit decision so they are all
  // visible together during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      code    <= '0;
      ch_sel  <= '0;
      D       <= '0;
      d_ch    <= '0;
      valid   <= 1'b0;
`ifdef ADC_AVG_EN
      acc     <= '0;
      sub     <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_ok) ch_sel <= scan ? '0 : ch_req;
        end
        SAMPLE: begin
          if (sample_end) begin
            cnt     <= '0;
            bit_idx <= BIT_W'(WIDTH - 1);
            code    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONVERT: begin
          if (bit_end) begin
            cnt     <= '0;
            code    <= code_kept;
            bit_idx <= bit_idx - 1'b1;
            if (conv_end) begin
`ifdef ADC_AVG_EN
              acc <= last_sub ? '0 : acc_sum;
              sub <= last_sub ? '0 : sub + 1'b1;
`endif
              if (last_sub) begin
                D     <= result;
                d_ch  <= ch_sel;
                valid <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
          if (valid && scan) ch_sel <= ch_next;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomised bench for sar_adc_ctrl: ideal comparator front end, expected codes and timing from SAR arithmetic.
`timescale 1ns/1ps
module tb_sar_adc_ctrl;

`ifdef ADC_AVG_EN
  localparam int SUBS = 4;
`else
  localparam int SUBS = 1;
`endif
  localparam int W0 = 10, N0 = 4, S0 = 4, T0 = 2;
  localparam int W1 = 12, N1 = 3, S1 = 4, T1 = 3;
  localparam int LAT0 = SUBS * (S0 + W0 * T0 + 1);
  localparam int LAT1 = SUBS * (S1 + W1 * T1 + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, scan0 = 1'b0;
  logic [1:0]    ch_req0 = '0;
  logic          cmp_in0;
  logic [W0-1:0] bitctrl0, D0;
  logic [1:0]    ch_sel0, d_ch0;
  logic          sample0, busy0, valid0;
  logic [W0-1:0] vin0 [N0];

  logic          start1 = 1'b0, scan1 = 1'b0;
  logic [1:0]    ch_req1 = '0;
  logic          cmp_in1;
  logic [W1-1:0] bitctrl1, D1;
  logic [1:0]    ch_sel1, d_ch1;
  logic          sample1, busy1, valid1;
  logic [W1-1:0] vin1 [4];

  assign cmp_in0 = (vin0[ch_sel0] >= bitctrl0);
  assign cmp_in1 = (vin1[ch_sel1] >= bitctrl1);

  sar_adc_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start0), .scan(scan0), .ch_req(ch_req0),
    .cmp_in(cmp_in0), .bitctrl(bitctrl0), .ch_sel(ch_sel0), .sample(sample0),
    .busy(busy0), .D(D0), .d_ch(d_ch0), .valid(valid0)
  );

  sar_adc_ctrl #(.WIDTH(W1), .NUM_CH(N1), .SAMPLE_CYCLES(S1), .SETTLE_CYCLES(T1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .scan(scan1), .ch_req(ch_req1),
    .cmp_in(cmp_in1), .bitctrl(bitctrl1), .ch_sel(ch_sel1), .sample(sample1),
    .busy(busy1), .D(D1), .d_ch(d_ch1), .valid(valid1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Single-shot on dut0; checks every MSB-first trial code of the first pass,
  // and injects an ignored start with a different channel mid-conversion.
  task automatic run_single0(input int ch, input int v);
    int lat;
    int j;
    int exp_trial;
    vin0[ch] = W0'(v);
    ch_req0  = 2'(ch);
    scan0    = 1'b0;
    start0   = 1'b1;
    lat      = -1;
    for (int k = 1; k <= LAT0 + 50; k++) begin
      @(negedge clk);
      start0 = (k == 7);
      if (k == 7) ch_req0 = 2'(ch + 1);
      if (k == 1) begin
        check("trk_sample", {31'd0, sample0}, 32'd1);
        check("trk_bitctrl", {22'd0, bitctrl0}, 32'd0);
      end
      if (k >= S0 + 1 && k < S0 + 1 + W0 * T0 && ((k - S0 - 1) % T0) == 0) begin
        j = W0 - 1 - (k - S0 - 1) / T0;
        exp_trial = (v & ~((1 << (j + 1)) - 1)) | (1 << j);
        check("trial", {22'd0, bitctrl0}, 32'(exp_trial));
      end
      if (valid0) begin
        lat = k;
        break;
      end
    end
    start0 = 1'b0;
    check("ss_latency", 32'(lat), 32'(LAT0));
    check("ss_D", {22'd0, D0}, 32'(v));
    check("ss_dch", {30'd0, d_ch0}, 32'(ch));
    @(negedge clk);
    check("ss_busy_after", {31'd0, busy0}, 32'd0);
    check("ss_valid_pulse", {31'd0, valid0}, 32'd0);
    check("ss_D_held", {22'd0, D0}, 32'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    int lat;
    int ch;
    int v;
    int exp_ch;
    for (int i = 0; i < N0; i++) vin0[i] = '0;
    for (int i = 0; i < 4; i++)  vin1[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_sample", {31'd0, sample0}, 32'd0);
    check("rst_bitctrl", {22'd0, bitctrl0}, 32'd0);
    check("rst_chsel", {30'd0, ch_sel0}, 32'd0);
    check("rst_D", {22'd0, D0}, 32'd0);
    check("rst_dch", {30'd0, d_ch0}, 32'd0);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_single0(2, 'h2A5);
    run_single0(1, 'h000);
    run_single0(3, 'h3FF);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N0; i++) vin0[i] = W0'($urandom_range(0, 1023));
      run_single0(int'($urandom_range(0, N0 - 1)), int'($urandom_range(0, 1023)));
    end

    // Round-robin scan; scan dropped part-way through the second ch1 pass.
    vin0[0] = 'h010; vin0[1] = 'h155; vin0[2] = 'h2AA; vin0[3] = 'h3F0;
    scan0  = 1'b1;
    start0 = 1'b1;
    for (int r = 0; r < 6; r++) begin
      exp_ch = r % N0;
      lat = -1;
      for (int k = 1; k <= LAT0 + 20; k++) begin
        @(negedge clk);
        start0 = 1'b0;
        if (r == 5 && k == 10) scan0 = 1'b0;
        if (valid0) begin
          lat = k;
          break;
        end
      end
      check("scan_interval", 32'(lat), 32'(LAT0));
      check("scan_dch", {30'd0, d_ch0}, 32'(exp_ch));
      check("scan_D", {22'd0, D0}, {22'd0, vin0[exp_ch]});
    end
    @(negedge clk);
    check("scan_stop_busy", {31'd0, busy0}, 32'd0);

    // Reset in the middle of a conversion.
    vin0[0] = 'h155;
    ch_req0 = '0;
    start0  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_sample", {31'd0, sample0}, 32'd0);
    check("midrst_bitctrl", {22'd0, bitctrl0}, 32'd0);
    check("midrst_D", {22'd0, D0}, 32'd0);
    check("midrst_valid", {31'd0, valid0}, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < LAT0 + 10; k++) begin
      @(negedge clk);
      if (valid0 || busy0) seen = 1;
    end
    check("midrst_quiet", 32'(seen), 32'd0);

    // dut1: out-of-range channel ignored, wider/slower conversion, 3-channel wrap.
    ch_req1 = 2'd3;
    start1  = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (busy1 || valid1) seen = 1;
      @(negedge clk);
    end
    check("bad_ch_ignored", 32'(seen), 32'd0);

    vin1[1] = 'hABC;
    ch_req1 = 2'd1;
    start1  = 1'b1;
    lat = -1;
    for (int k = 1; k <= LAT1 + 20; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (valid1) begin
        lat = k;
        break;
      end
    end
    check("w12_latency", 32'(lat), 32'(LAT1));
    check("w12_D", {20'd0, D1}, 32'h0ABC);
    check("w12_dch", {30'd0, d_ch1}, 32'd1);

    @(negedge clk);
    for (int i = 0; i < N1; i++) vin1[i] = W1'($urandom_range(0, 4095));
    scan1  = 1'b1;
    start1 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_ch = r % N1;
      lat = -1;
      for (int k = 1; k <= LAT1 + 20; k++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (valid1) begin
          lat = k;
          break;
        end
      end
      if (r == 3) scan1 = 1'b0;
      check("w12_scan_interval", 32'(lat), 32'(LAT1));
      check("w12_scan_dch", {30'd0, d_ch1}, 32'(exp_ch));
      check("w12_scan_D", {20'd0, D1}, {20'd0, vin1[exp_ch]});
    end
    @(negedge clk);
    check("w12_scan_stop", {31'd0, busy1}, 32'd0);

    ch = 0;
    v  = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
